fetch_stage: RTL

- Instruction-fetch stage that sits directly upstream of the register-read stage of the float pipeline.
- Reads 16-bit instruction words from a synchronous-read instruction memory with 1-cycle latency.
- Pairs each LI opcode (4'hA) with its following immediate word and presents one instruction per handshake downstream.
- Handles jump redirect/squash, downstream backpressure and halt-word detection.

---
 rtl/fetch_stage_if.sv | 33 +++
 rtl/fetch_stage.sv | 133 +++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory read port, redirect input and
// the downstream instruction handshake.
interface fetch_stage_if;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_ir;
  logic [15:0] out_imm;
  logic [15:0] out_pc;
  logic        halted;

  modport master (
    output mem_rd, mem_addr,
    input  mem_data,
    input  redirect, redirect_pc,
    output out_valid,
    input  out_ready,
    output out_ir, out_imm, out_pc, halted
  );

  modport slave (
    input  mem_rd, mem_addr,
    output mem_data,
    output redirect, redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_ir, out_imm, out_pc, halted
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: reads 16-bit words from a 1-cycle synchronous memory,
// pairs LI opcodes with their immediate and hands one instruction downstream.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  LI_OP    = 4'hA
) (
  input logic           clk,
  input logic           reset,
  fetch_stage_if.master bus
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {
    S_OP     = 2'd0,
    S_OPDATA = 2'd1,
    S_IMM    = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [DW-1:0]   ir_q, ir_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_ir_q, out_ir_d;
  logic [DW-1:0]   out_imm_q, out_imm_d;
  logic [AW-1:0]   out_pc_q, out_pc_d;
  logic            halted_q, halted_d;
  logic            mem_rd_c;
  logic [AW-1:0]   mem_addr_c;
  logic            slot_free_c;

  // Issuing only into a free slot guarantees the slot is empty when data returns.
  assign slot_free_c = !out_valid_q || bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_OP;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      out_valid_q <= 1'b0;
      out_ir_q    <= '0;
      out_imm_q   <= '0;
      out_pc_q    <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      out_valid_q <= out_valid_d;
      out_ir_q    <= out_ir_d;
      out_imm_q   <= out_imm_d;
      out_pc_q    <= out_pc_d;
      halted_q    <= halted_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    out_ir_d    = out_ir_q;
    out_imm_d   = out_imm_q;
    out_pc_d    = out_pc_q;
    halted_d    = halted_q;
    mem_rd_c    = 1'b0;
    mem_addr_c  = pc_q;

    case (state_q)
      S_OP: begin
        if (slot_free_c) begin
          mem_rd_c = 1'b1;
          state_d  = S_OPDATA;
        end
      end
      S_OPDATA: begin
        ir_d = bus.mem_data;
        if (bus.mem_data[15:12] == LI_OP) begin
          mem_rd_c   = 1'b1;
          mem_addr_c = pc_q + AW'(1);
          state_d    = S_IMM;
        end else if (bus.mem_data == DW'(0)) begin
          out_valid_d = 1'b1;
          out_ir_d    = '0;
          out_imm_d   = '0;
          out_pc_d    = pc_q;
          halted_d    = 1'b1;
          state_d     = S_HALT;
        end else begin
          out_valid_d = 1'b1;
          out_ir_d    = bus.mem_data;
          out_imm_d   = '0;
          out_pc_d    = pc_q;
          pc_d        = pc_q + AW'(1);
          state_d     = S_OP;
        end
      end
      S_IMM: begin
        out_valid_d = 1'b1;
        out_ir_d    = ir_q;
        out_imm_d   = bus.mem_data;
        out_pc_d    = pc_q;
        pc_d        = pc_q + AW'(2);
        state_d     = S_OP;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_OP;
      end
    endcase

    // Redirect squashes the output slot and any partial LI; stale read data is never sampled in S_OP.
    if (bus.redirect) begin
      pc_d        = bus.redirect_pc;
      state_d     = S_OP;
      out_valid_d = 1'b0;
      halted_d    = 1'b0;
    end
  end

  assign bus.mem_rd    = mem_rd_c && !reset;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ir    = out_ir_q;
  assign bus.out_imm   = out_imm_q;
  assign bus.out_pc    = out_pc_q;
  assign bus.halted    = halted_q;

endmodule
